// File: rtl/adc_capture_pkg.sv
// Shared types and default sizing for the ADC block capture slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package adc_capture_pkg;

  localparam int DEF_DATA_W    = 12;   // ADC sample width
  localparam int DEF_BLOCK_LEN = 256;  // sample pairs per captured block
  localparam int DEF_HOLDOFF   = 16;   // strobes ignored after each block
  localparam int OUT_W         = 16;   // FIFO word width per channel

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_CAPTURE,
    ST_HOLDOFF
  } cap_state_t;

endpackage

// File: rtl/adc_delta_detect.sv
// Channel-A step detector: holds the previous sample and flags |a - prev| > porog.
// Latency: trigger is combinational from the current strobe; prev_a updates one clk later.
// Backpressure: none; every load strobe is consumed in its own cycle.
module adc_delta_detect
  import adc_capture_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              load,
  input  logic [DATA_W-1:0] sample_a,
  input  logic [DATA_W-1:0] porog,
  output logic              trigger
);

  logic [DATA_W-1:0]        prev_a;
  logic                     prev_vld;
  logic signed [DATA_W:0]   diff;
  logic [DATA_W:0]          mag;

  // Magnitude of the step, one extra bit so the subtraction cannot wrap.
  always_comb begin
    diff    = $signed({1'b0, sample_a}) - $signed({1'b0, prev_a});
    mag     = diff[DATA_W] ? $unsigned(-diff) : $unsigned(diff);
    trigger = load && prev_vld && (mag > {1'b0, porog});
  end

  // Previous-sample register; clr wins so a fresh arming never compares against stale data.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_a   <= '0;
      prev_vld <= 1'b0;
    end else if (clr) begin
      prev_vld <= 1'b0;
    end else if (load) begin
      prev_a   <= sample_a;
      prev_vld <= 1'b1;
    end
  end

endmodule

// File: rtl/adc_block_capture.sv
// Triggered fixed-length ADC pair capture into a downstream FIFO (optional ADC_CAPTURE_SEQNUM_EN puts block_cnt in slot 0 of wr_data_b).
// Latency: each capture slot appears on wr_en/wr_data one clk after its sample_en.
// Backpressure: fifo_full drops the slot (sticky overflow); block length stays fixed in strobes.
module adc_block_capture
  import adc_capture_pkg::*;
#(
  parameter int BLOCK_LEN = DEF_BLOCK_LEN,
  parameter int HOLDOFF   = DEF_HOLDOFF,
  parameter int DATA_W    = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arm,
  input  logic              sample_en,
  input  logic [DATA_W-1:0] sample_a,
  input  logic [DATA_W-1:0] sample_b,
  input  logic [DATA_W-1:0] porog,
  input  logic              fifo_full,
  output logic              wr_en,
  output logic [OUT_W-1:0]  wr_data_a,
  output logic [OUT_W-1:0]  wr_data_b,
  output logic              block_done,
  output logic              busy,
  output logic              overflow,
  output logic [15:0]       block_cnt
);

  // HOLDOFF is expected to be at least 1 and BLOCK_LEN a power of two.
  localparam int SLOT_W = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
  localparam int HOLD_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(BLOCK_LEN - 1);
  localparam logic [HOLD_W-1:0] LAST_HOLD = HOLD_W'(HOLDOFF - 1);

  cap_state_t        state, state_nxt;
  logic [SLOT_W-1:0] slot_cnt;
  logic [SLOT_W-1:0] slot_idx;
  logic [HOLD_W-1:0] hold_cnt;
  logic              arm_q;
  logic              trig;
  logic              slot_vld;
  logic              slot_last;
  logic              prev_clr;
  logic              prev_load;

  assign prev_load = (state == ST_ARMED) && sample_en;
  assign busy      = (state == ST_CAPTURE);

  adc_delta_detect #(.DATA_W(DATA_W)) u_detect (
    .clk      (clk),
    .reset    (reset),
    .clr      (prev_clr),
    .load     (prev_load),
    .sample_a (sample_a),
    .porog    (porog),
    .trigger  (trig)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next state plus slot decode; the triggering strobe itself is slot 0.
  always_comb begin
    state_nxt = state;
    slot_vld  = 1'b0;
    slot_idx  = slot_cnt;
    slot_last = 1'b0;
    prev_clr  = 1'b0;
    case (state)
      ST_IDLE:    if (arm) state_nxt = ST_ARMED;
      ST_ARMED: begin
        if (!arm) begin
          state_nxt = ST_IDLE;
        end else if (trig) begin
          slot_vld = 1'b1;
          slot_idx = '0;
        end
      end
      ST_CAPTURE: if (sample_en) slot_vld = 1'b1;
      ST_HOLDOFF: begin
        if (sample_en && (hold_cnt == LAST_HOLD))
          state_nxt = arm ? ST_ARMED : ST_IDLE;
      end
      default:    state_nxt = ST_IDLE;
    endcase
    slot_last = slot_vld && (slot_idx == LAST_SLOT);
    if (slot_vld) state_nxt = slot_last ? ST_HOLDOFF : ST_CAPTURE;
    prev_clr = (state_nxt == ST_ARMED) && (state != ST_ARMED);
  end

  // Slot and holdoff counters; holdoff restarts whenever we are outside HOLDOFF.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_cnt <= '0;
      hold_cnt <= '0;
    end else begin
      if (slot_vld) slot_cnt <= slot_last ? '0 : slot_idx + 1'b1;
      if (state != ST_HOLDOFF) hold_cnt <= '0;
      else if (sample_en)      hold_cnt <= hold_cnt + 1'b1;
    end
  end

  // Registered write port, block bookkeeping and sticky overflow (a drop beats an arm re-rise).
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en      <= 1'b0;
      wr_data_a  <= '0;
      wr_data_b  <= '0;
      block_done <= 1'b0;
      overflow   <= 1'b0;
      block_cnt  <= '0;
      arm_q      <= 1'b0;
    end else begin
      arm_q      <= arm;
      wr_en      <= slot_vld && !fifo_full;
      block_done <= slot_last;
      if (slot_vld) begin
        wr_data_a <= OUT_W'(sample_a);
`ifdef ADC_CAPTURE_SEQNUM_EN
        wr_data_b <= (slot_idx == '0) ? block_cnt : OUT_W'(sample_b);
`else
        wr_data_b <= OUT_W'(sample_b);
`endif
      end
      if (slot_last) block_cnt <= block_cnt + 16'd1;
      if (slot_vld && fifo_full) overflow <= 1'b1;
      else if (arm && !arm_q)    overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adc_block_capture.sv
// Bench for adc_block_capture: directed blocks checked against a strobe-level reference model.
// Latency: model predicts outputs one clk after the sampled inputs.
// Backpressure: fifo_full driven per strobe by the directed vectors.
module tb_adc_block_capture;

  localparam int BL = 256;
  localparam int HO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        arm = 1'b0;
  logic        sample_en = 1'b0;
  logic [11:0] sample_a = '0;
  logic [11:0] sample_b = '0;
  logic [11:0] porog = 12'd100;
  logic        fifo_full = 1'b0;
  logic        wr_en;
  logic [15:0] wr_data_a;
  logic [15:0] wr_data_b;
  logic        block_done;
  logic        busy;
  logic        overflow;
  logic [15:0] block_cnt;

  always #40 clk = ~clk;

  adc_block_capture dut (
    .clk        (clk),
    .reset      (reset),
    .arm        (arm),
    .sample_en  (sample_en),
    .sample_a   (sample_a),
    .sample_b   (sample_b),
    .porog      (porog),
    .fifo_full  (fifo_full),
    .wr_en      (wr_en),
    .wr_data_a  (wr_data_a),
    .wr_data_b  (wr_data_b),
    .block_done (block_done),
    .busy       (busy),
    .overflow   (overflow),
    .block_cnt  (block_cnt)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // ---------------- reference model (strobe-level) ----------------
  // mode: 0 waiting for arm, 1 looking for a step, 2 inside a block, 3 ignoring strobes
  int m_mode, m_prev, m_slot, m_hold, d;
  bit m_pv, m_arm_prev, m_live, hit;
  bit exp_wr, exp_done, exp_ovf;
  int exp_cnt, exp_a, exp_b;

  task take_slot();
    if (fifo_full) exp_ovf = 1'b1;
    else begin
      exp_wr = 1'b1;
      exp_a  = int'(sample_a);
      exp_b  = int'(sample_b);
`ifdef ADC_CAPTURE_SEQNUM_EN
      if (m_slot == 0) exp_b = exp_cnt;
`endif
    end
    if (m_slot == BL - 1) begin
      exp_done = 1'b1;
      exp_cnt  = (exp_cnt + 1) % 65536;
      m_mode   = 3;
      m_hold   = 0;
    end else begin
      m_slot++;
      m_mode = 2;
    end
  endtask

  always @(posedge clk) begin
    exp_wr   = 1'b0;
    exp_done = 1'b0;
    m_live   = 1'b1;
    if (reset) begin
      m_mode = 0; m_pv = 0; m_slot = 0; m_hold = 0; m_arm_prev = 0;
      exp_ovf = 0; exp_cnt = 0; exp_a = 0; exp_b = 0;
    end else begin
      if (arm && !m_arm_prev) exp_ovf = 1'b0;
      m_arm_prev = arm;
      case (m_mode)
        0: if (arm) begin m_mode = 1; m_pv = 0; end
        1: begin
          if (!arm) m_mode = 0;
          else if (sample_en) begin
            d = int'(sample_a) - m_prev;
            if (d < 0) d = -d;
            hit = m_pv && (d > int'(porog));
            m_prev = int'(sample_a);
            m_pv = 1'b1;
            if (hit) begin m_slot = 0; take_slot(); end
          end
        end
        2: if (sample_en) take_slot();
        default: begin
          if (sample_en) begin
            m_hold++;
            if (m_hold == HO) begin m_mode = arm ? 1 : 0; m_pv = 0; end
          end
        end
      endcase
    end
  end

  int wr_seen = 0;
  int done_seen = 0;

  // Compare every cycle once the model has seen a clock edge.
  always @(negedge clk) begin
    if (m_live) begin
      chk("wr_en", 32'(wr_en), 32'(exp_wr));
      chk("block_done", 32'(block_done), 32'(exp_done));
      chk("busy", 32'(busy), 32'(m_mode == 2));
      chk("overflow", 32'(overflow), 32'(exp_ovf));
      chk("block_cnt", 32'(block_cnt), 32'(exp_cnt));
      if (exp_wr) begin
        chk("wr_data_a", 32'(wr_data_a), 32'(exp_a));
        chk("wr_data_b", 32'(wr_data_b), 32'(exp_b));
      end
      if (wr_en) wr_seen++;
      if (block_done) done_seen++;
    end
  end

  // ---------------- directed stimulus ----------------
  bit last_wr, last_done, done_at_end;
  int w0, d0, n;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input int a, input int b, input bit ff, input int gap);
    sample_a  = 12'(a);
    sample_b  = 12'(b);
    fifo_full = ff;
    sample_en = 1'b1;
    tick();
    sample_en = 1'b0;
    fifo_full = 1'b0;
    last_wr   = wr_en;
    last_done = block_done;
    repeat (gap) tick();
  endtask

  // Alternating large steps: returns the strobe number whose output carried the first write.
  task automatic find_trigger(output int cnt);
    cnt = -1;
    for (int i = 0; i < 40; i++) begin
      strobe((i % 2 == 1) ? 2000 : 0, 7, 1'b0, 0);
      if (last_wr) begin cnt = i + 1; break; end
    end
  endtask

  task automatic rest_of_block(input int base);
    for (int s = 1; s < BL; s++) strobe(base + s, s, 1'b0, 0);
    done_at_end = last_done;
  endtask

  initial begin
    #(80 * 60000);
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) tick();
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_block_cnt", 32'(block_cnt), 0);
    reset = 1'b0;
    tick();

    // Ramp of 10 per strobe never triggers; a +101 step does and becomes slot 0.
    arm = 1'b1;
    tick();
    w0 = wr_seen; d0 = done_seen;
    for (int i = 0; i < 10; i++) strobe(1000 + 10 * i, i, 1'b0, 1);
    tick();
    chk("ramp_writes", 32'(wr_seen - w0), 0);
    strobe(1191, 55, 1'b0, 0);
    chk("step_trigger", 32'(last_wr), 1);
    chk("step_slot0_a", 32'(wr_data_a), 1191);
    rest_of_block(2000);
    tick();
    chk("blk1_writes", 32'(wr_seen - w0), 256);
    chk("blk1_done_on_256th", 32'(done_at_end), 1);
    chk("blk1_dones", 32'(done_seen - d0), 1);
    chk("blk1_cnt", 32'(block_cnt), 1);
    for (int i = 0; i < HO; i++) strobe(3000, 0, 1'b0, 0);

    // Steps of exactly the threshold never trigger.
    w0 = wr_seen;
    strobe(500, 0, 1'b0, 0);
    strobe(600, 0, 1'b0, 0);
    strobe(500, 0, 1'b0, 0);
    strobe(600, 0, 1'b0, 0);
    tick();
    chk("exact_thr_writes", 32'(wr_seen - w0), 0);
    chk("exact_thr_busy", 32'(busy), 0);

    // Negative step of 101 triggers; slots 10..12 hit a full FIFO.
    w0 = wr_seen;
    strobe(499, 1, 1'b0, 0);
    chk("neg_step_trigger", 32'(last_wr), 1);
    for (int s = 1; s < BL; s++) strobe(s, s, (s >= 10 && s <= 12), 0);
    done_at_end = last_done;
    tick();
    chk("ovf_writes", 32'(wr_seen - w0), 253);
    chk("ovf_sticky", 32'(overflow), 1);
    chk("ovf_done_slot255", 32'(done_at_end), 1);
    chk("ovf_cnt", 32'(block_cnt), 2);
    for (int i = 0; i < HO; i++) strobe(3000, 0, 1'b0, 0);
    arm = 1'b0;
    tick();
    tick();
    chk("ovf_held_arm_low", 32'(overflow), 1);
    arm = 1'b1;
    tick();
    chk("ovf_cleared_rearm", 32'(overflow), 0);

    // porog=0 triggers on a change of 1; arm drop mid-block does not abort.
    porog = 12'd0;
    w0 = wr_seen;
    strobe(700, 0, 1'b0, 0);
    strobe(700, 0, 1'b0, 0);
    tick();
    chk("zero_thr_no_change", 32'(wr_seen - w0), 0);
    strobe(701, 9, 1'b0, 0);
    chk("zero_thr_trigger", 32'(last_wr), 1);
    porog = 12'd100;
    for (int s = 1; s < BL; s++) begin
      if (s == 50) arm = 1'b0;
      strobe(100 + s, s, 1'b0, 0);
    end
    done_at_end = last_done;
    tick();
    chk("armdrop_writes", 32'(wr_seen - w0), 256);
    chk("armdrop_done", 32'(done_at_end), 1);
    chk("armdrop_cnt", 32'(block_cnt), 3);
    for (int i = 0; i < HO; i++) strobe(3000, 0, 1'b0, 0);
    w0 = wr_seen;
    for (int i = 0; i < 4; i++) strobe((i % 2 == 1) ? 2000 : 0, 0, 1'b0, 0);
    tick();
    chk("idle_after_holdoff", 32'(wr_seen - w0), 0);

    // Reset in the cycle of slot 100 abandons the block.
    arm = 1'b1;
    tick();
    d0 = done_seen;
    find_trigger(n);
    chk("reset_blk_lead", 32'(n), 2);
    for (int s = 1; s < 100; s++) strobe(s, s, 1'b0, 0);
    reset = 1'b1;
    sample_a = 12'd333; sample_b = 12'd444; sample_en = 1'b1;
    tick();
    sample_en = 1'b0;
    chk("midrst_wr_en", 32'(wr_en), 0);
    chk("midrst_done", 32'(block_done), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_ovf", 32'(overflow), 0);
    chk("midrst_data_a", 32'(wr_data_a), 0);
    chk("midrst_data_b", 32'(wr_data_b), 0);
    chk("midrst_cnt", 32'(block_cnt), 0);
    reset = 1'b0;
    tick();
    chk("midrst_no_done", 32'(done_seen - d0), 0);

    // Three back-to-back blocks with arm held; 16 holdoff strobes + prime + trigger between them.
    for (int k = 0; k < 3; k++) begin
      find_trigger(n);
      chk("seq_lead_strobes", 32'(n), (k == 0) ? 2 : HO + 2);
`ifdef ADC_CAPTURE_SEQNUM_EN
      chk("seq_slot0_b", 32'(wr_data_b), 32'(k));
`else
      chk("seq_slot0_b", 32'(wr_data_b), 7);
`endif
      rest_of_block(k * 300);
      chk("seq_done", 32'(done_at_end), 1);
    end
    tick();
    chk("seq_cnt", 32'(block_cnt), 3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/adc_block_capture.md
ADC_BLOCK_CAPTURE -- requirements
Module: adc_block_capture

Interface
REQ-001 The block SHALL have a single clock; reset SHALL be synchronous and active-high.
REQ-002 Parameters SHALL be:
- BLOCK_LEN, 256, number of sample pairs per captured block.
- HOLDOFF, 16, sample strobes ignored after each block.
- DATA_W, 12, ADC sample width.
REQ-003 Ports SHALL be:
- clk  in  1  system clock (12.5 MHz domain)
- reset  in  1  synchronous active-high reset
- arm  in  1  level; capture permitted while high
- sample_en  in  1  one-cycle strobe, new ADC pair valid
- sample_a  in  DATA_W  ADC channel A sample
- sample_b  in  DATA_W  ADC channel B sample
- porog  in  DATA_W  trigger threshold, unsigned
- fifo_full  in  1  downstream FIFO full
- wr_en  out  1  FIFO write strobe
- wr_data_a  out  16  {4'd0, sample_a}
- wr_data_b  out  16  {4'd0, sample_b}
- block_done  out  1  one-cycle pulse on last write slot of a block
- busy  out  1  high while in CAPTURE
- overflow  out  1  sticky, a write was dropped
- block_cnt  out  16  completed-block counter

Function
REQ-004 The FSM SHALL have the states IDLE, ARMED, CAPTURE and HOLDOFF.
REQ-005 IDLE SHALL go to ARMED on the first clk with arm=1. sample_en SHALL be ignored in IDLE.
REQ-006 On entry to ARMED the previous-sample valid flag SHALL be cleared. The first sample_en SHALL only load prev_a and SHALL NOT trigger.
REQ-007 Trigger condition SHALL be: in ARMED, sample_en=1, prev valid, and |sample_a - prev_a| > porog, with the difference computed signed at DATA_W+1 bits. The comparison SHALL be strict; porog=0 triggers on any change.
REQ-008 When the trigger condition holds, the triggering sample SHALL be capture slot 0. prev_a SHALL update on every sample_en in ARMED.
REQ-009 Every capture slot SHALL produce registered outputs exactly one clk after its sample_en: wr_en=1 and data for one cycle.
REQ-010 CAPTURE SHALL consume one slot per sample_en, counting 0..BLOCK_LEN-1. block_done SHALL assert in the output cycle of slot BLOCK_LEN-1; the FSM SHALL then go to HOLDOFF.
REQ-011 If fifo_full=1 in the cycle of a slot's sample_en, that slot SHALL be dropped: wr_en=0, overflow set, and the slot counter still advances (block length is fixed in time).
REQ-012 HOLDOFF SHALL count HOLDOFF sample_en strobes, then go to ARMED if arm=1, else IDLE.
REQ-013 Deasserting arm in ARMED SHALL return to IDLE next clk. Deasserting arm in CAPTURE or HOLDOFF SHALL NOT abort; the block completes.
REQ-014 block_cnt SHALL increment by 1 on each block_done and wrap from 0xFFFF to 0.
REQ-015 overflow SHALL clear only on reset or on a rising edge of arm.
REQ-016 busy SHALL be 1 exactly while the state is CAPTURE.
REQ-017 sample_en asserted on consecutive clocks SHALL each be processed; no strobe SHALL be lost.

Reset
REQ-018 On reset the state SHALL be IDLE; wr_en, block_done, busy and overflow SHALL be 0; wr_data_a, wr_data_b and block_cnt SHALL be 0; the slot counter, holdoff counter and prev valid flag SHALL be cleared.
REQ-019 Reset mid-CAPTURE SHALL abandon the block without a block_done pulse, and block_cnt SHALL become 0.

Configuration
REQ-020 With ADC_CAPTURE_SEQNUM_EN defined, wr_data_b of slot 0 SHALL carry block_cnt (pre-increment value) instead of the sample.
REQ-021 Without ADC_CAPTURE_SEQNUM_EN, wr_data_b SHALL always be {4'd0, sample_b}.

Structure
REQ-022 A shared package adc_capture_pkg SHALL hold the state enum, DATA_W and the default BLOCK_LEN and HOLDOFF constants.
REQ-023 A sub-module adc_delta_detect SHALL contain the prev_a register, the valid flag and the |diff|>porog compare, with a registered-free trigger output.

Verification
REQ-024 Stimulus: porog=100, ramp A by 10 per strobe, then step +101 -> trigger on the step sample; 256 wr_en; block_done on the 256th; block_cnt=1.
REQ-025 Stimulus: step of exactly +100 with porog=100 -> no trigger; FSM stays ARMED, wr_en never asserts.
REQ-026 Stimulus: fifo_full high for slots 10-12 -> 253 wr_en; overflow=1; block_done still at slot 255; overflow cleared by an arm re-rise.
REQ-027 Stimulus: reset at slot 100 -> all outputs 0 next clk; no block_done; block_cnt=0.
REQ-028 Stimulus: with ADC_CAPTURE_SEQNUM_EN, three blocks with arm held -> wr_data_b slot 0 = 0, 1, 2; exactly 16 strobes of HOLDOFF between blocks.
REQ-029 Stimulus: arm dropped at slot 50 -> block completes to 256; FSM goes to IDLE after HOLDOFF.
